// File: rtl/maquina_maluca_monitor.sv
// Passive monitor for the coffee-machine controller state bus: checks each observed
// transition, latches the first violation, and reports completed brews.
module maquina_maluca_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       state,
    input  logic             clear_err,
    output logic             cafe_pronto,
    output logic [CNT_W-1:0] cafe_count,
    output logic [3:0]       brew_len,
    output logic             busy,
    output logic             erro,
    output logic [2:0]       erro_code
);

    typedef enum logic [3:0] {
        StIdle     = 4'd1,
        StLigar    = 4'd2,
        StVerif    = 4'd3,
        StEncher   = 4'd4,
        StMoer     = 4'd5,
        StColocar  = 4'd6,
        StPassar   = 4'd7,
        StTampear  = 4'd8,
        StExtracao = 4'd9
    } ctrl_state_e;

    logic [3:0]       prev_state_q, prev_state_d;
    logic             start_q, start_d;
    logic             agua_ok_q, agua_ok_d;
    logic [3:0]       len_cnt_q, len_cnt_d;
    logic             cafe_pronto_q, cafe_pronto_d;
    logic [CNT_W-1:0] cafe_count_q, cafe_count_d;
    logic [3:0]       brew_len_q, brew_len_d;
    logic             busy_q, busy_d;
    logic             erro_q, erro_d;
    logic [2:0]       erro_code_q, erro_code_d;

    logic [3:0] exp_next;
    logic [2:0] cause;
    logic       illegal;
    logic       brew_start;
    logic       brew_done;

    // Only one successor is legal from any state; IDLE and VERIF depend on start/agua.
    always_comb begin
        exp_next = 4'd0;
        case (prev_state_q)
            StIdle:     exp_next = start_q ? StLigar : StIdle;
            StLigar:    exp_next = StVerif;
            StVerif:    exp_next = agua_ok_q ? StMoer : StEncher;
            StEncher:   exp_next = StVerif;
            StMoer:     exp_next = StColocar;
            StColocar:  exp_next = StPassar;
            StPassar:   exp_next = StTampear;
            StTampear:  exp_next = StExtracao;
            StExtracao: exp_next = StIdle;
            default:    exp_next = 4'd0;
        endcase

        illegal = (state == 4'd0) || (state > 4'd9);
        cause   = 3'd0;
        if (illegal) begin
            cause = 3'd1;
        end else if (state != exp_next) begin
            if (prev_state_q == StIdle && (state == StIdle || state == StLigar)) begin
                cause = 3'd3;
            end else if (prev_state_q == StVerif && (state == StEncher || state == StMoer)) begin
                cause = 3'd4;
            end else begin
                cause = 3'd2;
            end
        end

        brew_start = (prev_state_q == StIdle) && (state == StLigar) && start_q;
        brew_done  = (prev_state_q == StExtracao) && (state == StIdle);
    end

    always_comb begin
        prev_state_d  = state;
        start_d       = start;
        agua_ok_d     = agua_ok_q | (state == StEncher);
        busy_d        = (state != StIdle);
        cafe_pronto_d = brew_done;
        brew_len_d    = brew_done ? len_cnt_q : brew_len_q;

        cafe_count_d = cafe_count_q;
        if (brew_done && cafe_count_q != {CNT_W{1'b1}}) begin
            cafe_count_d = cafe_count_q + CNT_W'(1);
        end

        len_cnt_d = len_cnt_q;
        if (brew_start) begin
            len_cnt_d = 4'd1;
        end else if (state != StIdle && len_cnt_q != 4'd15) begin
            len_cnt_d = len_cnt_q + 4'd1;
        end

        // A violation on a clearing edge re-latches rather than being lost.
        erro_d      = erro_q;
        erro_code_d = erro_code_q;
        if (cause != 3'd0 && (!erro_q || clear_err)) begin
            erro_d      = 1'b1;
            erro_code_d = cause;
        end else if (clear_err) begin
            erro_d      = 1'b0;
            erro_code_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q  <= StIdle;
            start_q       <= 1'b0;
            agua_ok_q     <= 1'b0;
            len_cnt_q     <= 4'd0;
            cafe_pronto_q <= 1'b0;
            cafe_count_q  <= '0;
            brew_len_q    <= 4'd0;
            busy_q        <= 1'b0;
            erro_q        <= 1'b0;
            erro_code_q   <= 3'd0;
        end else begin
            prev_state_q  <= prev_state_d;
            start_q       <= start_d;
            agua_ok_q     <= agua_ok_d;
            len_cnt_q     <= len_cnt_d;
            cafe_pronto_q <= cafe_pronto_d;
            cafe_count_q  <= cafe_count_d;
            brew_len_q    <= brew_len_d;
            busy_q        <= busy_d;
            erro_q        <= erro_d;
            erro_code_q   <= erro_code_d;
        end
    end

    assign cafe_pronto = cafe_pronto_q;
    assign cafe_count  = cafe_count_q;
    assign brew_len    = brew_len_q;
    assign busy        = busy_q;
    assign erro        = erro_q;
    assign erro_code   = erro_code_q;

endmodule
